// File: rtl/store_commit_controller_pkg.sv
// Shared types for the store commit path: store queue indices, commit counts,
// block/physical address paths and the commit FSM phase encoding.
package store_commit_controller_pkg;

    localparam int STORE_QUEUE_ENTRY_NUM           = 16;
    localparam int STORE_QUEUE_ENTRY_NUM_BIT_WIDTH = $clog2(STORE_QUEUE_ENTRY_NUM);
    localparam int COMMIT_WIDTH                    = 2;
    localparam int COMMIT_STORE_COUNT_WIDTH        = $clog2(COMMIT_WIDTH + 1);
    localparam int PHY_ADDR_WIDTH                  = 32;
    localparam int LSQ_BLOCK_WORD_WIDTH            = 2;
    localparam int LSQ_BLOCK_ADDR_WIDTH            = PHY_ADDR_WIDTH - LSQ_BLOCK_WORD_WIDTH;

    typedef logic [STORE_QUEUE_ENTRY_NUM_BIT_WIDTH-1:0] StoreQueueIndexPath;
    typedef logic [STORE_QUEUE_ENTRY_NUM_BIT_WIDTH:0]   StoreCommitCountPath;
    typedef logic [COMMIT_STORE_COUNT_WIDTH-1:0]        CommitStoreCountPath;
    typedef logic [LSQ_BLOCK_ADDR_WIDTH-1:0]            LSQ_BlockAddrPath;
    typedef logic [PHY_ADDR_WIDTH-1:0]                  PhyAddrPath;

    // Write sequencing phase for the entry at the store queue head.
    typedef enum logic [1:0] {
        STORE_COMMIT_IDLE        = 2'd0,
        STORE_COMMIT_ISSUE       = 2'd1,
        STORE_COMMIT_WAIT_RESP   = 2'd2,
        STORE_COMMIT_WAIT_REFILL = 2'd3
    } StoreCommitPhase;

    function automatic PhyAddrPath LSQ_ToFullAddrFromBlockAddr(input LSQ_BlockAddrPath blockAddr);
        return {blockAddr, {LSQ_BLOCK_WORD_WIDTH{1'b0}}};
    endfunction

    // Queue depth need not be a power of two, so wrap explicitly.
    function automatic StoreQueueIndexPath incrementStoreQueueIndex(input StoreQueueIndexPath index);
        if (index == StoreQueueIndexPath'(STORE_QUEUE_ENTRY_NUM - 1))
            return '0;
        else
            return index + StoreQueueIndexPath'(1);
    endfunction

endpackage

// File: rtl/store_commit_perf_counter.sv
// Wrapping 32-bit event counters for the store commit path: hit writes,
// missed writes and cycles spent waiting for a refill.
module store_commit_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeHit,
    input  logic        writeMiss,
    input  logic        refillStall,
    output logic [31:0] perfWriteCount,
    output logic [31:0] perfMissCount,
    output logic [31:0] perfRefillStallCycles
);

    // Count each event class; counters wrap naturally on overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perfWriteCount        <= '0;
            perfMissCount         <= '0;
            perfRefillStallCycles <= '0;
        end else begin
            if (writeHit)    perfWriteCount        <= perfWriteCount + 32'd1;
            if (writeMiss)   perfMissCount         <= perfMissCount + 32'd1;
            if (refillStall) perfRefillStallCycles <= perfRefillStallCycles + 32'd1;
        end
    end

endmodule

// File: rtl/store_commit_controller.sv
// Drains committed store queue entries, oldest first, into the D-cache write
// port: issue, wait for the response, reissue after a refill on a miss, then
// release the entry. Failed store-conditionals are released without a write.
// Optional macro RSD_STORE_COMMIT_PERF_COUNTER_EN adds performance counters.
//
// Handshake: dcWrReq is a valid that stays high with a stable payload until
// the cycle dcWrReady is high; that cycle is the transfer. Exactly one
// dcWrRespValid follows each transfer.
module store_commit_controller
    import store_commit_controller_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  CommitStoreCountPath commitCount,
    output StoreQueueIndexPath  sqReadIndex,
    input  LSQ_BlockAddrPath    sqAddress,
    input  logic [31:0]         sqData,
    input  logic [3:0]          sqByteWE,
    input  logic                sqCondEnabled,
    output logic                dcWrReq,
    input  logic                dcWrReady,
    output PhyAddrPath          dcWrAddr,
    output logic [31:0]         dcWrData,
    output logic [3:0]          dcWrByteWE,
    input  logic                dcWrRespValid,
    input  logic                dcWrMiss,
    input  logic                dcRefillDone,
    output logic                releaseValid,
    output StoreQueueIndexPath  releaseIndex,
    output logic                committedEmpty,
    output StoreCommitPhase     debugPhase
`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
    ,
    output logic [31:0]         perfWriteCount,
    output logic [31:0]         perfMissCount,
    output logic [31:0]         perfRefillStallCycles
`endif
);

    StoreCommitPhase     phase;
    StoreQueueIndexPath  headPtr;
    StoreCommitCountPath committedCount;
    logic                pending;
    logic                respHit;
    logic                respMiss;

    // Decode pending work, responses and the release strobe from the current phase.
    always_comb begin
        pending      = (committedCount != '0);
        respHit      = (phase == STORE_COMMIT_WAIT_RESP) && dcWrRespValid && !dcWrMiss;
        respMiss     = (phase == STORE_COMMIT_WAIT_RESP) && dcWrRespValid && dcWrMiss;
        releaseValid = respHit ||
                       ((phase == STORE_COMMIT_IDLE) && pending && !sqCondEnabled);
    end

    assign sqReadIndex    = headPtr;
    assign releaseIndex   = headPtr;
    assign dcWrAddr       = LSQ_ToFullAddrFromBlockAddr(sqAddress);
    assign dcWrData       = sqData;
    assign dcWrByteWE     = sqByteWE;
    assign dcWrReq        = (phase == STORE_COMMIT_ISSUE);
    assign committedEmpty = (committedCount == '0);
    assign debugPhase     = phase;

    // Write sequencing FSM plus head pointer and committed-entry bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase          <= STORE_COMMIT_IDLE;
            headPtr        <= '0;
            committedCount <= '0;
        end else begin
            committedCount <= committedCount + StoreCommitCountPath'(commitCount)
                                             - StoreCommitCountPath'(releaseValid);
            if (releaseValid)
                headPtr <= incrementStoreQueueIndex(headPtr);
            unique case (phase)
                STORE_COMMIT_IDLE:
                    if (pending && sqCondEnabled) phase <= STORE_COMMIT_ISSUE;
                STORE_COMMIT_ISSUE:
                    if (dcWrReady) phase <= STORE_COMMIT_WAIT_RESP;
                STORE_COMMIT_WAIT_RESP:
                    if (respMiss)     phase <= STORE_COMMIT_WAIT_REFILL;
                    else if (respHit) phase <= STORE_COMMIT_IDLE;
                STORE_COMMIT_WAIT_REFILL:
                    if (dcRefillDone) phase <= STORE_COMMIT_ISSUE;
                default:
                    phase <= STORE_COMMIT_IDLE;
            endcase
        end
    end

    // Committing more stores than the queue holds is an upstream error.
    assert property (@(posedge clk) disable iff (!rst)
        (int'(committedCount) + int'(commitCount)) <= STORE_QUEUE_ENTRY_NUM);

`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
    store_commit_perf_counter perfCounter (
        .clk                   (clk),
        .rst                   (rst),
        .writeHit              (respHit),
        .writeMiss             (respMiss),
        .refillStall           (phase == STORE_COMMIT_WAIT_REFILL),
        .perfWriteCount        (perfWriteCount),
        .perfMissCount         (perfMissCount),
        .perfRefillStallCycles (perfRefillStallCycles)
    );
`endif

endmodule

// File: tb/tb_store_commit_controller.sv
// Bench for store_commit_controller: acts as the store queue, applies a
// cycle-by-cycle vector table, scoreboards write payloads and release order,
// and finishes with reset-during-refill and recovery sequences.
module tb_store_commit_controller;
    import store_commit_controller_pkg::*;

    logic                clk;
    logic                rst;
    CommitStoreCountPath commitCount;
    StoreQueueIndexPath  sqReadIndex;
    LSQ_BlockAddrPath    sqAddress;
    logic [31:0]         sqData;
    logic [3:0]          sqByteWE;
    logic                sqCondEnabled;
    logic                dcWrReq;
    logic                dcWrReady;
    PhyAddrPath          dcWrAddr;
    logic [31:0]         dcWrData;
    logic [3:0]          dcWrByteWE;
    logic                dcWrRespValid;
    logic                dcWrMiss;
    logic                dcRefillDone;
    logic                releaseValid;
    StoreQueueIndexPath  releaseIndex;
    logic                committedEmpty;
    StoreCommitPhase     debugPhase;
`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
    logic [31:0]         perfWriteCount;
    logic [31:0]         perfMissCount;
    logic [31:0]         perfRefillStallCycles;
`endif

    store_commit_controller dut (
        .clk            (clk),
        .rst            (rst),
        .commitCount    (commitCount),
        .sqReadIndex    (sqReadIndex),
        .sqAddress      (sqAddress),
        .sqData         (sqData),
        .sqByteWE       (sqByteWE),
        .sqCondEnabled  (sqCondEnabled),
        .dcWrReq        (dcWrReq),
        .dcWrReady      (dcWrReady),
        .dcWrAddr       (dcWrAddr),
        .dcWrData       (dcWrData),
        .dcWrByteWE     (dcWrByteWE),
        .dcWrRespValid  (dcWrRespValid),
        .dcWrMiss       (dcWrMiss),
        .dcRefillDone   (dcRefillDone),
        .releaseValid   (releaseValid),
        .releaseIndex   (releaseIndex),
        .committedEmpty (committedEmpty),
        .debugPhase     (debugPhase)
`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
        ,
        .perfWriteCount        (perfWriteCount),
        .perfMissCount         (perfMissCount),
        .perfRefillStallCycles (perfRefillStallCycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- store queue model ----------------
    LSQ_BlockAddrPath memAddr [STORE_QUEUE_ENTRY_NUM];
    logic [31:0]      memData [STORE_QUEUE_ENTRY_NUM];
    logic [3:0]       memBe   [STORE_QUEUE_ENTRY_NUM];
    logic             memCond [STORE_QUEUE_ENTRY_NUM];

    assign sqAddress     = memAddr[sqReadIndex];
    assign sqData        = memData[sqReadIndex];
    assign sqByteWE      = memBe[sqReadIndex];
    assign sqCondEnabled = memCond[sqReadIndex];

    // ---------------- scoreboard ----------------
    logic [STORE_QUEUE_ENTRY_NUM_BIT_WIDTH-1:0] exp_q[$];
    int unsigned tailModel;
    int nVec;
    int nFail;
    int curVec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, curVec, act, exp);
        end
    endtask

    // Check every presented write against the oldest expected entry and pop on release.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (dcWrReq === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nVec++; nFail++;
                    $display("FAIL wrUnexpected (step %0d): write with no committed entry", curVec);
                end else begin
                    chk("wrAddr", dcWrAddr, {memAddr[exp_q[0]], 2'b00});
                    chk("wrData", dcWrData, memData[exp_q[0]]);
                    chk("wrByteWE", 32'(dcWrByteWE), 32'(memBe[exp_q[0]]));
                end
            end
            if (releaseValid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    nVec++; nFail++;
                    $display("FAIL relUnexpected (step %0d): release with no committed entry", curVec);
                end else begin
                    chk("releaseOrder", 32'(releaseIndex), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int c, input logic rdy, input logic resp, input logic miss,
                        input logic refill);
        @(posedge clk);
        #1;
        commitCount   = CommitStoreCountPath'(c);
        dcWrReady     = rdy;
        dcWrRespValid = resp;
        dcWrMiss      = miss;
        dcRefillDone  = refill;
        for (int k = 0; k < c; k++) begin
            exp_q.push_back(STORE_QUEUE_ENTRY_NUM_BIT_WIDTH'(tailModel));
            tailModel = (tailModel == STORE_QUEUE_ENTRY_NUM - 1) ? 0 : tailModel + 1;
        end
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   commit;
        logic rdy, resp, miss, refill;
        logic eReq, eRel, eEmpty;
        int   eHead;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input int c, input logic rdy, input logic resp,
                                   input logic miss, input logic refill, input logic eReq,
                                   input logic eRel, input logic eEmpty, input int eHead);
        vec_t v;
        v.commit = c; v.rdy = rdy; v.resp = resp; v.miss = miss; v.refill = refill;
        v.eReq = eReq; v.eRel = eRel; v.eEmpty = eEmpty; v.eHead = eHead;
        vecs.push_back(v);
    endfunction

    initial begin
        nVec = 0; nFail = 0; curVec = -1; tailModel = 0;
        for (int i = 0; i < STORE_QUEUE_ENTRY_NUM; i++) begin
            memAddr[i] = LSQ_BlockAddrPath'($urandom);
            memData[i] = $urandom;
            memBe[i]   = 4'($urandom_range(1, 15));
            memCond[i] = (i <= 1 || i == 15);
        end
        memData[0] = 32'hDEAD_BEEF;
        memBe[0]   = 4'hF;

        // entry 0: ready stalled 3 cycles, then hit
        addVec(1,0,0,0,0, 0,0,1,0);
        addVec(0,0,0,0,0, 0,0,0,0);
        addVec(0,0,0,0,0, 1,0,0,0);
        addVec(0,0,0,0,0, 1,0,0,0);
        addVec(0,0,0,0,0, 1,0,0,0);
        addVec(0,1,0,0,0, 1,0,0,0);
        addVec(0,0,0,0,0, 0,0,0,0);
        addVec(0,0,1,0,0, 0,1,0,0);
        // entry 1: stray response in ISSUE, miss, 5 refill cycles, reissue, hit
        addVec(1,0,0,0,0, 0,0,1,1);
        addVec(0,0,0,0,0, 0,0,0,1);
        addVec(0,1,1,0,0, 1,0,0,1);
        addVec(0,0,1,1,1, 0,0,0,1);
        addVec(0,0,0,0,0, 0,0,0,1);
        addVec(0,0,1,0,0, 0,0,0,1);
        addVec(0,0,0,0,0, 0,0,0,1);
        addVec(0,0,0,0,0, 0,0,0,1);
        addVec(0,0,0,0,1, 0,0,0,1);
        addVec(0,1,0,0,0, 1,0,0,1);
        addVec(0,0,1,0,0, 0,1,0,1);
        // entries 2..4: failed SC, released on consecutive cycles
        addVec(2,0,0,0,0, 0,0,1,2);
        addVec(1,0,0,0,0, 0,1,0,2);
        addVec(0,0,0,0,0, 0,1,0,3);
        addVec(0,0,0,0,0, 0,1,0,4);
        // entries 5..14: failed SC, commit 2 alongside each release (+1 net)
        addVec(2,0,0,0,0, 0,0,1,5);
        for (int h = 5; h <= 8; h++) addVec(2,0,0,0,0, 0,1,0,h);
        for (int h = 9; h <= 14; h++) addVec(0,0,0,0,0, 0,1,0,h);
        // entries 15 and 0: written across the wrap
        addVec(2,0,0,0,0, 0,0,1,15);
        addVec(0,0,0,0,0, 0,0,0,15);
        addVec(0,1,0,0,0, 1,0,0,15);
        addVec(0,0,1,0,0, 0,1,0,15);
        addVec(0,0,0,0,0, 0,0,0,0);
        addVec(0,1,0,0,0, 1,0,0,0);
        addVec(0,0,1,0,0, 0,1,0,0);
        addVec(0,0,0,0,0, 0,0,1,1);

        // reset with a commit held; nothing may be committed
        rst = 1'b0; commitCount = CommitStoreCountPath'(1);
        dcWrReady = 0; dcWrRespValid = 0; dcWrMiss = 0; dcRefillDone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("resetEmpty", 32'(committedEmpty), 32'd1);
        chk("resetReq", 32'(dcWrReq), 32'd0);
        chk("resetRelease", 32'(releaseValid), 32'd0);
        chk("resetHead", 32'(sqReadIndex), 32'd0);
        chk("resetPhase", 32'(debugPhase), 32'(STORE_COMMIT_IDLE));
        rst = 1'b1; commitCount = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            curVec = i;
            step(vecs[i].commit, vecs[i].rdy, vecs[i].resp, vecs[i].miss, vecs[i].refill);
            chk("dcWrReq", 32'(dcWrReq), 32'(vecs[i].eReq));
            chk("releaseValid", 32'(releaseValid), 32'(vecs[i].eRel));
            chk("committedEmpty", 32'(committedEmpty), 32'(vecs[i].eEmpty));
            chk("headIndex", 32'(releaseIndex), 32'(vecs[i].eHead));
        end

        // reset while waiting for a refill
        curVec = 1000;
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        step(0,0,1,1,0);
        step(0,0,0,0,0);
        chk("phaseRefill", 32'(debugPhase), 32'(STORE_COMMIT_WAIT_REFILL));
        chk("pendingBeforeReset", 32'(committedEmpty), 32'd0);
`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
        chk("perfWrite", perfWriteCount, 32'd4);
        chk("perfMiss", perfMissCount, 32'd2);
        chk("perfStall", perfRefillStallCycles, 32'd5);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0; commitCount = CommitStoreCountPath'(1);
        @(posedge clk);
        #1;
        rst = 1'b1; commitCount = '0; dcRefillDone = 1'b1;
        exp_q.delete();
        tailModel = 0;
        @(negedge clk);
        chk("abortReq", 32'(dcWrReq), 32'd0);
        chk("abortPhase", 32'(debugPhase), 32'(STORE_COMMIT_IDLE));
        chk("abortHead", 32'(sqReadIndex), 32'd0);
        chk("abortEmpty", 32'(committedEmpty), 32'd1);
`ifdef RSD_STORE_COMMIT_PERF_COUNTER_EN
        chk("perfWriteReset", perfWriteCount, 32'd0);
        chk("perfMissReset", perfMissCount, 32'd0);
        chk("perfStallReset", perfRefillStallCycles, 32'd0);
`endif
        for (int k = 0; k < 2; k++) begin
            step(0,0,0,0,1);
            chk("lateRefillReq", 32'(dcWrReq), 32'd0);
            chk("lateRefillPhase", 32'(debugPhase), 32'(STORE_COMMIT_IDLE));
        end

        // recovery: one fresh write from entry 0
        curVec = 2000;
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        chk("recoverReq", 32'(dcWrReq), 32'd1);
        step(0,0,1,0,0);
        chk("recoverRelease", 32'(releaseValid), 32'd1);
        step(0,0,0,0,0);
        chk("recoverEmpty", 32'(committedEmpty), 32'd1);
        chk("recoverHead", 32'(releaseIndex), 32'd1);
        chk("queueDrained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
